// File: rtl/fill_rect.sv
// Rectangle filler: scans a clipped region column-major and streams one pixel
// per accepted handshake to the VGA adapter, in solid, gradient or checker modes.
module fill_rect #(
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] colour,
  input  logic [1:0]    mode,
  input  logic          plot_ready,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} state_t;

  localparam logic [XW-1:0] X_MAX = XW'(SCR_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(SCR_H - 1);

  state_t        state, state_nxt;
  logic [XW-1:0] x_q, x0_q, x1_q;
  logic [YW-1:0] y_q, y0_q, y1_q;
  logic [CW-1:0] colour_q;
  logic [1:0]    mode_q;

  logic [XW-1:0] x1_clip;
  logic [YW-1:0] y1_clip;
  logic          region_empty;
  logic          accept;
  logic          last_pix;
  logic [CW-1:0] pix_colour;

  assign x1_clip      = (x1 > X_MAX) ? X_MAX : x1;
  assign y1_clip      = (y1 > Y_MAX) ? Y_MAX : y1;
  // Off-screen origins always exceed the clipped corner, so this also covers them.
  assign region_empty = (x0 > x1_clip) || (y0 > y1_clip) || (x0 > X_MAX) || (y0 > Y_MAX);

  // Handshake: vga_plot is the valid; a pixel transfers on a clk edge where
  // vga_plot && plot_ready. While plot_ready is low, x/y/colour are held.
  assign accept   = (state == FILL) && plot_ready;
  assign last_pix = (x_q == x1_q) && (y_q == y1_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = region_empty ? DONE : FILL;
      FILL: if (accept && last_pix) state_nxt = DONE;
      DONE: if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_colour = colour_q;
    case (mode_q)
      2'd1:    pix_colour = colour_q + x_q[CW-1:0];
      2'd2:    pix_colour = (x_q[0] ^ y_q[0]) ? ~colour_q : colour_q;
      default: pix_colour = colour_q;
    endcase
  end

  always_comb begin
    busy       = (state == FILL);
    done       = (state == DONE);
    vga_plot   = (state == FILL);
    vga_x      = x_q;
    vga_y      = y_q;
    vga_colour = (state == FILL) ? pix_colour : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      colour_q <= '0;
      mode_q   <= '0;
    end else begin
      if (state == IDLE && start) begin
        x0_q     <= x0;
        y0_q     <= y0;
        x1_q     <= x1_clip;
        y1_q     <= y1_clip;
        colour_q <= colour;
        mode_q   <= mode;
        x_q      <= region_empty ? '0 : x0;
        y_q      <= region_empty ? '0 : y0;
      end else if (accept && !last_pix) begin
        // Column-major: y runs fastest, x steps when a column completes.
        if (y_q == y1_q) begin
          y_q <= y0_q;
          x_q <= x_q + 1'b1;
        end else begin
          y_q <= y_q + 1'b1;
        end
      end
    end
  end

endmodule
